// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - prefetching instruction fetch unit feeding the instruction register
//
// Holds the fetch PC, reads instruction words from memory one request at a
// time, buffers them with their addresses in a small in-order prefetch queue,
// and hands one word per decoder request to the instruction register through
// a one-cycle active-low load strobe. A jump flushes the queue and redirects
// fetching; a read that was already in flight when the jump arrived is still
// completed on the bus, but its word is thrown away.
//
// Ports:
//   clock      - system clock, all state changes on the rising edge
//   reset      - synchronous active-high reset
//   mem_read   - registered read request to memory
//   mem_addr   - registered word address, stable while mem_read=1 until ack
//   mem_ack    - memory returns valid mem_data this cycle (used only while reading)
//   mem_data   - returned instruction word
//   next       - decoder wants a new instruction (level)
//   jump       - one-cycle redirect pulse
//   jump_addr  - new fetch address, taken when jump=1
//   ir_data    - registered instruction word for the instruction register
//   notLoad    - registered active-low load strobe, low one cycle per instruction
//   ir_pc      - registered address of the word on ir_data
//   empty      - prefetch queue holds no words

module instruction_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  input  logic        next,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic [15:0] ir_data,
  output logic        notLoad,
  output logic [15:0] ir_pc,
  output logic        empty
);

  // Occupancy counter wide enough for the largest supported DEPTH (4).
  localparam int            CW      = 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          mem_read_nx;
  logic [15:0]   mem_addr_nx;
  logic [15:0]   fetch_pc, fetch_pc_nx;
  logic [CW-1:0] count, count_nx;
  logic [CW-1:0] wr_idx;
  logic          do_push, do_pop, free;

  // Entry 0 is always the head; a pop shifts the rest down by one.
  logic [15:0]   q_word [DEPTH];
  logic [15:0]   q_addr [DEPTH];

  assign empty = (count == '0);

  always_comb begin
    do_pop      = next && (count != '0) && !jump;
    do_push     = (state == REQ) && mem_ack && !jump;
    // With a simultaneous pop the pushed word lands behind the survivors.
    wr_idx      = do_pop ? count - CW'(1) : count;

    count_nx    = count;
    if (jump)
      count_nx = '0;
    else if (do_push && !do_pop)
      count_nx = count + CW'(1);
    else if (!do_push && do_pop)
      count_nx = count - CW'(1);

    fetch_pc_nx = fetch_pc;
    if (jump)
      fetch_pc_nx = jump_addr;
    else if (do_push)
      fetch_pc_nx = fetch_pc + 16'd1;

    // free: no request remains outstanding after this edge, so a new one
    // may be issued in the same edge.
    free        = 1'b0;
    state_nx    = state;
    mem_read_nx = mem_read;
    mem_addr_nx = mem_addr;

    case (state)
      IDLE:    free = 1'b1;
      REQ: begin
        if (mem_ack)
          free = 1'b1;
        else if (jump)
          state_nx = DISCARD;   // bus request must complete at the old address
      end
      DISCARD: begin
        if (mem_ack)
          free = 1'b1;
      end
      default: free = 1'b1;
    endcase

    if (free) begin
      if (count_nx < DEPTH_C) begin
        state_nx    = REQ;
        mem_read_nx = 1'b1;
        mem_addr_nx = fetch_pc_nx;
      end else begin
        state_nx    = IDLE;
        mem_read_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      mem_read <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      count    <= '0;
      ir_data  <= 16'h0000;
      ir_pc    <= 16'h0000;
      notLoad  <= 1'b1;
    end else begin
      state    <= state_nx;
      mem_read <= mem_read_nx;
      mem_addr <= mem_addr_nx;
      fetch_pc <= fetch_pc_nx;
      count    <= count_nx;

      if (do_pop) begin
        notLoad <= 1'b0;
        ir_data <= q_word[0];
        ir_pc   <= q_addr[0];
      end else begin
        notLoad <= 1'b1;
      end
    end
  end

  // Queue storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_word[i] <= q_word[i+1];
        q_addr[i] <= q_addr[i+1];
      end
    end
    // Placed after the shift so the push wins on a shared slot.
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (CW'(i) == wr_idx)) begin
        q_word[i] <= mem_data;
        q_addr[i] <= mem_addr;
      end
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream neighbour of the instruction register; sits between memory and the decoder-facing instruction register.
- Holds the fetch PC and issues word reads to memory over a req/ack handshake.
- Buffers returned words in a small prefetch queue.
- Drives the instruction register's 16-bit data input and its active-low load strobe, one instruction per decoder request.
- Jumps flush the queue and redirect fetching.

Parameters:
- DEPTH, 2, prefetch queue entries (1..4).
- RESET_PC, 16'h0000, fetch address after reset.

Ports:
- clock  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_read  output  1  read request; registered.
- mem_addr  output  16  word address of the read; registered, stable while mem_read=1.
- mem_ack  input  1  memory has valid mem_data this cycle; sampled only while mem_read=1.
- mem_data  input  16  returned instruction word.
- next  input  1  decoder wants a new instruction (level).
- jump  input  1  redirect fetch; one-cycle pulse.
- jump_addr  input  16  new fetch address, sampled when jump=1.
- ir_data  output  16  instruction word to the instruction register; registered.
- notLoad  output  1  active-low load strobe to the instruction register; registered.
- ir_pc  output  16  address of the word on ir_data; registered.
- empty  output  1  queue occupancy is 0.

Behaviour:
- Reset values: mem_read=0, mem_addr=RESET_PC, ir_data=0, notLoad=1, ir_pc=0, queue empty, fetch PC=RESET_PC, state=IDLE.
- Reset overrides all other inputs in the same cycle. Reset mid-request drops the request with no discard phase; memory must tolerate an abandoned read.
- States:
  - IDLE: no request outstanding.
  - REQ: mem_read=1 for the fetch PC.
  - DISCARD: mem_read=1 for a stale address; the returned word is dropped.
- Only one request is outstanding at a time.
- Issue rule: at an edge where the state is, or becomes, free of an outstanding request, enter REQ with mem_addr=fetch PC if occupancy after that edge < DEPTH. Otherwise go to IDLE.
- REQ, ack edge:
  - push mem_data together with its address;
  - fetch PC <= fetch PC+1, wrapping 16'hFFFF -> 16'h0000;
  - re-apply the issue rule in the same edge. Back-to-back requests therefore produce no idle cycle when space exists.
- mem_addr and mem_read must not change while in REQ or DISCARD until the ack edge.
- Pop: at an edge with next=1, occupancy>0 and jump=0:
  - notLoad<=0, ir_data<=head word, ir_pc<=head address;
  - remove the head.
  - At every other edge, notLoad<=1 and ir_data/ir_pc hold.
  - notLoad is therefore low for exactly one cycle per instruction.
  - With next held high and words available, one pop per cycle.
- Push and pop on the same edge are allowed. Occupancy is unchanged and the pushed word goes behind the remaining entries (no bypass).
- Minimum latency, request issue to strobe: ack edge N pushes; pop at edge N+1; notLoad low in the cycle after N+1.
- Jump has priority over both pop and push. At an edge with jump=1:
  - queue cleared, no pop, notLoad<=1;
  - fetch PC <= jump_addr.
  - From IDLE: go to REQ at jump_addr.
  - From REQ with no ack this edge: go to DISCARD; mem_addr holds the old address.
  - From REQ with ack this edge: drop the word and go to REQ at jump_addr.
- DISCARD on its ack edge: drop the word and apply the issue rule at fetch PC.
- A jump while in DISCARD only updates fetch PC.
- empty reflects the registered occupancy.

Test Plan:
- Reset, then memory acks every request one cycle after mem_read rises, next=1 continuously, mem_data=addr^16'hA5A5 → mem_addr sequence 0,1,2,…; notLoad pulses low once per instruction; ir_data/ir_pc match the address sequence with no gaps.
- next=0, DEPTH=2 → exactly two reads complete, then mem_read=0. Raising next yields ir_data for addresses 0 then 1, after which fetching resumes at 2.
- Memory acks after 4 wait cycles → mem_addr stable through the wait; a single notLoad pulse per word.
- jump to 16'h1234 while a request to 3 is outstanding → the word for 3 is discarded and mem_read stays high on 3 until ack. The next request is 16'h1234, and the first delivered ir_pc is 16'h1234.
- Jump coinciding with next=1 and a non-empty queue → no notLoad pulse that cycle; the queue is empty afterwards.
- Fetch PC starting at 16'hFFFE → addresses FFFE, FFFF, 0000.
- reset asserted mid-REQ with a pending ack → all outputs return to reset values on the next edge; the ack is ignored.
